// File: rtl/mod6_counter_pkg.sv
// Shared timer-digit definitions: BCD digit type, per-digit maxima and the load clamp.
package mod6_counter_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_digit_t;

    localparam bcd_digit_t MOD6_MAX  = 4'd5;
    localparam bcd_digit_t MOD10_MAX = 4'd9;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_DEC,
        OP_LOAD
    } digit_op_e;

    // Keypad entries above the digit's maximum saturate so an illegal value never lands in the register.
    function automatic bcd_digit_t clamp_digit(input bcd_digit_t value, input bcd_digit_t max_value);
        return (value > max_value) ? max_value : value;
    endfunction

endpackage

// File: rtl/mod6_counter_if.sv
// Digit bus for one countdown digit: load/enable in, value and borrow/zero flags out.
interface mod6_counter_if;
    import mod6_counter_pkg::*;

    bcd_digit_t data;
    logic       loadn;
    logic       en;
    bcd_digit_t ones;
    logic       tc;
    logic       zero;

    modport master (
        output data, loadn, en,
        input  ones, tc, zero
    );

    modport slave (
        input  data, loadn, en,
        output ones, tc, zero
    );

endinterface

// File: rtl/mod6_counter.sv
// Tens-of-seconds digit: mod-6 BCD down-counter with async clear, sync clamped load and borrow-out.
module mod6_counter
    import mod6_counter_pkg::*;
(
    input logic           clk,
    input logic           clrn,
    mod6_counter_if.slave bus
);

    bcd_digit_t ones_q;
    bcd_digit_t ones_d;
    bcd_digit_t load_val;
    digit_op_e  op;
    logic       is_zero;

    assign load_val = clamp_digit(bus.data, MOD6_MAX);
    assign is_zero  = (ones_q == '0);

    // Load outranks count enable; a simultaneous borrow-in is dropped for that edge.
    always_comb begin
        op = OP_HOLD;
        if (!bus.loadn) begin
            op = OP_LOAD;
        end else if (bus.en) begin
            op = OP_DEC;
        end
    end

    always_comb begin
        ones_d = ones_q;
        case (op)
            OP_LOAD: ones_d = load_val;
            OP_DEC:  ones_d = is_zero ? MOD6_MAX : (ones_q - 4'd1);
            default: ones_d = ones_q;
        endcase
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

    assign bus.ones = ones_q;
    assign bus.zero = is_zero;
    assign bus.tc   = bus.en & is_zero;

endmodule

// File: tb/tb_mod6_counter.sv
// Directed bench for mod6_counter: reset, load/count/wrap, hold, clamp, load priority, async clear.
module tb_mod6_counter;

    logic clk;
    logic clrn;
    int   n_pass;
    int   n_total;

    mod6_counter_if bus ();

    mod6_counter dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_digit(input string tag, input logic [3:0] exp_ones, input logic exp_tc,
                               input logic exp_zero);
        check({tag, ".ones"}, bus.ones, exp_ones);
        check({tag, ".tc"},   {3'b0, bus.tc},   {3'b0, exp_tc});
        check({tag, ".zero"}, {3'b0, bus.zero}, {3'b0, exp_zero});
    endtask

    initial begin
        n_pass      = 0;
        n_total     = 0;
        clrn        = 1'b0;
        bus.en      = 1'b1;
        bus.loadn   = 1'b1;
        bus.data    = 4'd0;

        // Reset held with en high
        #2;
        check_digit("rst_pre_edge", 4'd0, 1'b1, 1'b1);
        tick();
        check_digit("rst_edge1", 4'd0, 1'b1, 1'b1);
        tick();
        check_digit("rst_edge2", 4'd0, 1'b1, 1'b1);

        // Release between edges: nothing moves until the next edge, which wraps 0 -> 5
        #2;
        clrn = 1'b1;
        #1;
        check_digit("release_no_edge", 4'd0, 1'b1, 1'b1);
        tick();
        check_digit("release_first_edge", 4'd5, 1'b0, 1'b0);

        // Load 4 with en high, then count 3,2,1,0,5,4
        bus.loadn = 1'b0;
        bus.data  = 4'd4;
        tick();
        bus.loadn = 1'b1;
        #1;
        check_digit("load4", 4'd4, 1'b0, 1'b0);
        tick(); check_digit("cnt3", 4'd3, 1'b0, 1'b0);
        tick(); check_digit("cnt2", 4'd2, 1'b0, 1'b0);
        tick(); check_digit("cnt1", 4'd1, 1'b0, 1'b0);
        tick(); check_digit("cnt0", 4'd0, 1'b1, 1'b1);
        tick(); check_digit("wrap5", 4'd5, 1'b0, 1'b0);
        tick(); check_digit("cnt4", 4'd4, 1'b0, 1'b0);

        // Hold at 3 with en low for five edges
        bus.en    = 1'b0;
        bus.loadn = 1'b0;
        bus.data  = 4'd3;
        tick();
        bus.loadn = 1'b1;
        bus.data  = 4'd0;
        #1;
        check_digit("hold_load3", 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_digit("hold3", 4'd3, 1'b0, 1'b0);
        end

        // Zero with en low: zero set, no borrow
        bus.loadn = 1'b0;
        bus.data  = 4'd0;
        tick();
        check_digit("zero_en_low", 4'd0, 1'b0, 1'b1);

        // Load clamp
        bus.data = 4'd9;  tick(); check("clamp9", bus.ones, 4'd5);
        bus.data = 4'd1;  tick(); check("load1", bus.ones, 4'd1);
        bus.data = 4'd15; tick(); check("clamp15", bus.ones, 4'd5);
        bus.data = 4'd2;  tick(); check("load2", bus.ones, 4'd2);
        bus.data = 4'd6;  tick(); check("clamp6", bus.ones, 4'd5);
        bus.data = 4'd5;  tick(); check("load5", bus.ones, 4'd5);

        // Load priority over enable at ones = 0
        bus.data = 4'd0;
        tick();
        check("prio_setup0", bus.ones, 4'd0);
        bus.en   = 1'b1;
        bus.data = 4'd2;
        #1;
        check("prio_tc_before", {3'b0, bus.tc}, 4'd1);
        tick();
        bus.loadn = 1'b1;
        #1;
        check_digit("prio_loaded2", 4'd2, 1'b0, 1'b0);
        tick();
        check("prio_resume1", bus.ones, 4'd1);

        // Async clear between edges at ones = 3
        bus.en    = 1'b0;
        bus.loadn = 1'b0;
        bus.data  = 4'd3;
        tick();
        bus.loadn = 1'b1;
        bus.en    = 1'b1;
        check("clr_setup3", bus.ones, 4'd3);
        #2;
        clrn = 1'b0;
        #1;
        check_digit("clr_immediate", 4'd0, 1'b1, 1'b1);

        // Clear dominates a pending load
        bus.loadn = 1'b0;
        bus.data  = 4'd4;
        tick();
        check("clr_over_load", bus.ones, 4'd0);
        #2;
        clrn      = 1'b1;
        bus.loadn = 1'b1;
        bus.en    = 1'b0;
        tick();
        check_digit("clr_release_hold", 4'd0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
